// File: rtl/transmissor_serial_6.sv
// transmissor_serial_6 -- serial transmitter for 6-bit words.
// On an accepted start request the word is captured and sent as one frame
// on an idle-high line: start(0), dados[0..5] LSB first, even parity, stop(1).
// Each bit lasts TICKS_POR_BIT clocks.
//
// Ports:
//   clock        system clock, rising edge
//   reset        synchronous, active-high, dominates all other inputs
//   partida      start request, sampled only while idle (INICIAL)
//   dados[5:0]   word to send, captured together with partida
//   saida_serial registered serial line, idle high
//   ocupado      high while a frame is on the line
//   pronto       one-cycle pulse in the cycle after the stop bit
module transmissor_serial_6 #(
  parameter int TICKS_POR_BIT = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       partida,
  input  logic [5:0] dados,
  output logic       saida_serial,
  output logic       ocupado,
  output logic       pronto
);

  localparam int TW = $clog2(TICKS_POR_BIT);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_POR_BIT - 1);
  localparam logic [3:0]    BIT_LAST  = 4'd8;

  typedef enum logic [1:0] {
    INICIAL     = 2'd0,
    TRANSMISSAO = 2'd1,
    FINAL       = 2'd2
  } estado_t;

  estado_t       state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [3:0]    bit_q, bit_d;
  logic [8:0]    shreg_q, shreg_d;
  logic          saida_q, saida_d;
  logic          ocupado_q, ocupado_d;
  logic          pronto_q, pronto_d;

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    unique case (state_q)
      INICIAL: begin
        if (partida) begin
          // Whole frame is loaded at once; bit 0 of the shift register is
          // always the bit currently on the line.
          shreg_d = {1'b1, ^dados, dados, 1'b0};
          tick_d  = '0;
          bit_d   = '0;
          state_d = TRANSMISSAO;
        end
      end
      TRANSMISSAO: begin
        if (tick_q == TICK_LAST) begin
          tick_d = '0;
          if (bit_q == BIT_LAST) begin
            state_d = FINAL;
          end else begin
            bit_d   = bit_q + 4'd1;
            shreg_d = {1'b1, shreg_q[8:1]};
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      FINAL:   state_d = INICIAL;
      default: state_d = INICIAL;
    endcase
  end

  // Outputs are registered from the next state so the line changes in the
  // very cycle the FSM enters a state (start bit appears at k+1).
  always_comb begin
    saida_d   = (state_d == TRANSMISSAO) ? shreg_d[0] : 1'b1;
    ocupado_d = (state_d == TRANSMISSAO);
    pronto_d  = (state_d == FINAL);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= INICIAL;
      tick_q    <= '0;
      bit_q     <= '0;
      shreg_q   <= '1;
      saida_q   <= 1'b1;
      ocupado_q <= 1'b0;
      pronto_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      shreg_q   <= shreg_d;
      saida_q   <= saida_d;
      ocupado_q <= ocupado_d;
      pronto_q  <= pronto_d;
    end
  end

  assign saida_serial = saida_q;
  assign ocupado      = ocupado_q;
  assign pronto       = pronto_q;

endmodule

// File: tb/tb_transmissor_serial_6.sv
// Bench for transmissor_serial_6 with TICKS_POR_BIT = 4. A frame-level model
// (acceptance cycle + captured word) predicts line/ocupado/pronto each cycle
// from the cycle offset since acceptance.
module tb_transmissor_serial_6;
  localparam int T = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       partida = 1'b0;
  logic [5:0] dados = '0;
  logic       saida_serial, ocupado, pronto;

  transmissor_serial_6 #(.TICKS_POR_BIT(T)) dut (
    .clock        (clock),
    .reset        (reset),
    .partida      (partida),
    .dados        (dados),
    .saida_serial (saida_serial),
    .ocupado      (ocupado),
    .pronto       (pronto)
  );

  always #5 clock = ~clock;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  bit         checking = 1'b0;
  bit         busy     = 1'b0;
  int         k        = 0;
  logic [5:0] word     = '0;
  int         pronto_cnt = 0;

  function automatic logic frame_bit(logic [5:0] w, int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 6) return w[idx-1];
    if (idx == 7) return ^w;
    return 1'b1;
  endfunction

  task automatic chk(string tag, logic obs, logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk_int(string tag, int obs, int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock cycle: check outputs of the current cycle, then drive inputs
  // that the closing rising edge will sample.
  task automatic step(logic r, logic p, logic [5:0] d);
    int   off;
    logic el, eo, ep;
    @(negedge clock);
    el = 1'b1; eo = 1'b0; ep = 1'b0;
    if (busy) begin
      off = cyc - k;
      if (off >= 1 && off <= 9*T) begin
        eo = 1'b1;
        el = frame_bit(word, (off - 1) / T);
      end else if (off == 9*T + 1) begin
        ep = 1'b1;
      end else begin
        busy = 1'b0;
      end
    end
    if (checking) begin
      chk("saida_serial", saida_serial, el);
      chk("ocupado", ocupado, eo);
      chk("pronto", pronto, ep);
    end
    if (pronto === 1'b1) pronto_cnt++;
    reset = r; partida = p; dados = d;
    if (r) busy = 1'b0;
    else if (p && !busy) begin
      busy = 1'b1; k = cyc; word = d;
    end
    @(posedge clock);
    cyc++;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 6'($urandom));
  endtask

  initial begin
    // reset, then 20 quiet cycles
    step(1'b1, 1'b0, '0);
    step(1'b1, 1'b0, '0);
    checking = 1'b1;
    step(1'b1, 1'b0, '0);
    idle(20);

    // single frames with distinct words
    pronto_cnt = 0;
    step(1'b0, 1'b1, 6'b101101); idle(40);
    chk_int("pronto_101101", pronto_cnt, 1);
    step(1'b0, 1'b1, 6'b000001); idle(40);
    step(1'b0, 1'b1, 6'b111111); idle(40);
    step(1'b0, 1'b1, 6'b000000); idle(40);
    chk_int("pronto_3words", pronto_cnt, 4);

    // new request + new dados during the parity bit is ignored
    pronto_cnt = 0;
    step(1'b0, 1'b1, 6'b101101);
    idle(29);
    step(1'b0, 1'b1, 6'b010101);
    idle(15);
    chk_int("pronto_ignored_req", pronto_cnt, 1);

    // partida held high: three back-to-back frames
    pronto_cnt = 0;
    for (int i = 0; i <= 2*(9*T+3); i++) step(1'b0, 1'b1, 6'($urandom));
    idle(45);
    chk_int("pronto_back2back", pronto_cnt, 3);

    // reset during data bit 3 aborts the frame
    pronto_cnt = 0;
    step(1'b0, 1'b1, 6'b110010);
    idle(17);
    step(1'b1, 1'b0, '0);
    idle(40);
    chk_int("pronto_after_abort", pronto_cnt, 0);
    step(1'b0, 1'b1, 6'b011011); idle(40);
    chk_int("pronto_after_recover", pronto_cnt, 1);

    // reset and partida together: no frame
    pronto_cnt = 0;
    step(1'b1, 1'b1, 6'b101010);
    idle(40);
    chk_int("pronto_reset_wins", pronto_cnt, 0);

    // random traffic
    for (int i = 0; i < 3000; i++)
      step(($urandom % 97) == 0, ($urandom % 4) == 0, 6'($urandom));
    idle(45);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
